// File: rtl/spi_regbank_slave_if.sv
// SPI pin bundle between an SPI master and spi_regbank_slave.
// Pin names follow the slave's point of view: _i enters the slave, _o leaves it.
interface spi_regbank_slave_if;
  logic sclk_i;
  logic mosi_i;
  logic cs_n_i;
  logic miso_o;
  logic miso_oe_o;

  modport slave  (input  sclk_i, mosi_i, cs_n_i, output miso_o, miso_oe_o);
  modport master (output sclk_i, mosi_i, cs_n_i, input  miso_o, miso_oe_o);
endinterface

// File: rtl/spi_regbank_slave.sv
// SPI mode-0 slave, oversampled in clk, exposing a bank of 8-bit registers (reg 0 = read-only ID).
// Latency: a pin edge reaches the internal edge pulse 3 clk later; writes land on that edge, with no backpressure.
module spi_regbank_slave #(
  parameter int         NUM_REGS = 8,
  parameter logic [7:0] ID_VALUE = 8'h96
) (
  input  logic                    clk,
  input  logic                    rst_n,
  spi_regbank_slave_if.slave      spi,
  output logic [8*NUM_REGS-1:0]   regs_o,
  output logic                    wr_strobe_o,
  output logic [6:0]              wr_addr_o
);

  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic                    r_mosi_s1, r_mosi_s2;
  logic                    r_cs_s1, r_cs_s2, r_cs_d;
  logic [2:0]              r_bit_cnt;
  logic [7:0]              r_shift_in;
  logic [7:0]              r_rd_shift;
  logic [6:0]              r_addr;
  logic [8*NUM_REGS-1:0]   r_bank;
  logic                    r_wr_strobe;
  logic [6:0]              r_wr_addr;

  logic                    w_sclk_rise, w_sclk_fall, w_cs_fall;
  logic                    w_active, w_last, w_wr_ok;
  logic [7:0]              w_byte;
  logic [6:0]              w_addr_nxt;
  logic [AW-1:0]           w_wr_idx;

  function automatic logic f_in_range(input logic [6:0] a);
    return ({1'b0, a} < 8'(NUM_REGS));
  endfunction

  function automatic logic [7:0] f_rd(input logic [6:0] a, input logic [8*NUM_REGS-1:0] bank);
    logic [AW-1:0] idx;
    idx = a[AW-1:0];
    return f_in_range(a) ? bank[{idx, 3'b000} +: 8] : 8'h00;
  endfunction

  function automatic logic [6:0] f_adv(input logic [6:0] a);
    return (a == 7'(NUM_REGS - 1)) ? 7'd0 : a + 7'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_d    <= 1'b1;
    end else begin
      r_sclk_s1 <= spi.sclk_i;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_mosi_s1 <= spi.mosi_i;
      r_mosi_s2 <= r_mosi_s1;
      r_cs_s1   <= spi.cs_n_i;
      r_cs_s2   <= r_cs_s1;
      r_cs_d    <= r_cs_s2;
    end
  end

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
  assign w_cs_fall   = ~r_cs_s2 & r_cs_d;
  assign w_active    = ~r_cs_s2 && (r_state != S_IDLE);
  assign w_byte      = {r_shift_in[6:0], r_mosi_s2};
  assign w_last      = w_active && w_sclk_rise && (r_bit_cnt == 3'd7);
  assign w_addr_nxt  = f_adv(r_addr);
  assign w_wr_idx    = r_addr[AW-1:0];
  assign w_wr_ok     = w_last && (r_state == S_WDATA) && (r_addr != 7'd0) && f_in_range(r_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_cs_s2) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_cs_fall) w_state_nxt = S_CMD;
        S_CMD:   if (w_last)    w_state_nxt = w_byte[7] ? S_RDATA : S_WDATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= 3'd0;
      r_shift_in  <= 8'h00;
      r_rd_shift  <= 8'h00;
      r_addr      <= 7'd0;
      r_bank      <= {{(8*(NUM_REGS-1)){1'b0}}, ID_VALUE};
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 7'd0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (!w_active) begin
        r_bit_cnt  <= 3'd0;
        r_shift_in <= 8'h00;
        r_rd_shift <= 8'h00;
      end else begin
        if (w_sclk_rise) begin
          r_shift_in <= w_byte;
          r_bit_cnt  <= r_bit_cnt + 3'd1;
        end
        // The fall right after a reload would discard the freshly loaded MSB before the master samples it.
        if (w_sclk_fall && (r_state == S_RDATA) && (r_bit_cnt != 3'd0))
          r_rd_shift <= {r_rd_shift[6:0], 1'b0};
        if (w_last) begin
          case (r_state)
            S_CMD: begin
              r_addr <= w_byte[6:0];
              if (w_byte[7]) r_rd_shift <= f_rd(w_byte[6:0], r_bank);
            end
            S_WDATA: begin
              r_addr <= w_addr_nxt;
              if (w_wr_ok) begin
                r_bank[{w_wr_idx, 3'b000} +: 8] <= w_byte;
                r_wr_strobe                     <= 1'b1;
                r_wr_addr                       <= r_addr;
              end
            end
            S_RDATA: begin
              r_addr     <= w_addr_nxt;
              r_rd_shift <= f_rd(w_addr_nxt, r_bank);
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign spi.miso_o    = (r_state == S_RDATA) & r_rd_shift[7];
  assign spi.miso_oe_o = ~r_cs_s2;
  assign regs_o        = r_bank;
  assign wr_strobe_o   = r_wr_strobe;
  assign wr_addr_o     = r_wr_addr;

endmodule

// File: tb/tb_spi_regbank_slave.sv
// Directed bench for spi_regbank_slave: SPI master tasks drive frames, results compared against hand-computed values.
module tb_spi_regbank_slave;
  localparam int NUM_REGS = 8;
  localparam int HALF     = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [8*NUM_REGS-1:0] regs_o;
  logic                  wr_strobe_o;
  logic [6:0]            wr_addr_o;
  int                    n_checks   = 0;
  int                    n_errors   = 0;
  int                    strobe_cnt = 0;

  spi_regbank_slave_if u_if ();

  spi_regbank_slave #(.NUM_REGS(NUM_REGS), .ID_VALUE(8'h96)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi         (u_if),
    .regs_o      (regs_o),
    .wr_strobe_o (wr_strobe_o),
    .wr_addr_o   (wr_addr_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_strobe_o) strobe_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic rx);
    u_if.mosi_i = b;
    wait_clk(HALF);
    rx = u_if.miso_o;
    u_if.sclk_i = 1'b1;
    wait_clk(HALF);
    u_if.sclk_i = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic cs_low();
    u_if.cs_n_i = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    u_if.cs_n_i = 1'b1;
    wait_clk(2 * HALF);
  endtask

  function automatic logic [7:0] reg_at(input int k);
    return regs_o[8*k +: 8];
  endfunction

  initial begin
    logic [7:0] rx;
    logic       b;
    int         s0;

    rst_n       = 1'b0;
    u_if.sclk_i = 1'b0;
    u_if.mosi_i = 1'b0;
    u_if.cs_n_i = 1'b1;
    wait_clk(3);
    check("rst_regs",   regs_o, 64'h96);
    check("rst_oe",     u_if.miso_oe_o, 0);
    check("rst_miso",   u_if.miso_o, 0);
    check("rst_strobe", wr_strobe_o, 0);
    check("rst_waddr",  wr_addr_o, 0);
    rst_n = 1'b1;
    wait_clk(5);

    // single write
    s0 = strobe_cnt;
    cs_low();
    check("oe_active", u_if.miso_oe_o, 1);
    spi_byte(8'h03, rx);
    spi_byte(8'hA5, rx);
    cs_high();
    check("single_reg3",    reg_at(3), 8'hA5);
    check("single_strobes", strobe_cnt - s0, 1);
    check("single_waddr",   wr_addr_o, 3);
    check("oe_idle",        u_if.miso_oe_o, 0);

    // burst write wrapping past reg 7 into protected reg 0
    s0 = strobe_cnt;
    cs_low();
    spi_byte(8'h06, rx);
    spi_byte(8'h11, rx);
    spi_byte(8'h22, rx);
    spi_byte(8'h33, rx);
    spi_byte(8'h44, rx);
    cs_high();
    check("burst_regs",    regs_o, 64'h2211_0000_A500_4496);
    check("burst_strobes", strobe_cnt - s0, 3);
    check("burst_waddr",   wr_addr_o, 1);

    // overwrite reg1, then burst read from 0
    cs_low();
    spi_byte(8'h01, rx);
    spi_byte(8'h5A, rx);
    cs_high();
    check("preload_reg1", reg_at(1), 8'h5A);
    cs_low();
    spi_byte(8'h80, rx);
    check("rd_cmd_miso", rx, 8'h00);
    spi_byte(8'h00, rx);
    check("rd_byte0", rx, 8'h96);
    spi_byte(8'h00, rx);
    check("rd_byte1", rx, 8'h5A);
    spi_byte(8'h00, rx);
    check("rd_byte2", rx, 8'h00);
    cs_high();

    // read across the top of the bank
    cs_low();
    spi_byte(8'h87, rx);
    spi_byte(8'h00, rx);
    check("rd_wrap7", rx, 8'h22);
    spi_byte(8'h00, rx);
    check("rd_wrap0", rx, 8'h96);
    cs_high();

    // ID protection and out-of-range read
    s0 = strobe_cnt;
    cs_low();
    spi_byte(8'h00, rx);
    spi_byte(8'hFF, rx);
    cs_high();
    check("id_protect", reg_at(0), 8'h96);
    cs_low();
    spi_byte(8'h90, rx);
    spi_byte(8'h00, rx);
    check("rd_oor", rx, 8'h00);
    cs_high();
    check("prot_strobes", strobe_cnt - s0, 0);
    check("prot_waddr",   wr_addr_o, 1);

    // abort mid-byte, then a clean frame must still work
    s0 = strobe_cnt;
    cs_low();
    spi_byte(8'h02, rx);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
    cs_high();
    check("abort_reg2",    reg_at(2), 8'h00);
    check("abort_strobes", strobe_cnt - s0, 0);
    cs_low();
    spi_byte(8'h02, rx);
    spi_byte(8'h3C, rx);
    cs_high();
    check("recover_regs",    regs_o, 64'h2211_0000_A53C_5A96);
    check("recover_strobes", strobe_cnt - s0, 1);
    check("recover_waddr",   wr_addr_o, 2);

    // reset in the middle of a burst
    cs_low();
    spi_byte(8'h05, rx);
    spi_byte(8'h77, rx);
    wait_clk(4);
    check("pre_rst_reg5", reg_at(5), 8'h77);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, b);
    rst_n = 1'b0;
    #1;
    check("mid_rst_regs",   regs_o, 64'h96);
    check("mid_rst_waddr",  wr_addr_o, 0);
    check("mid_rst_oe",     u_if.miso_oe_o, 0);
    check("mid_rst_miso",   u_if.miso_o, 0);
    check("mid_rst_strobe", wr_strobe_o, 0);
    u_if.cs_n_i = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
